// File: rtl/rtc_bus_sched_if.sv
// Requester-side and RTC-pin signals of the bus scheduler, bundled as one port.
interface rtc_bus_sched_if;
    logic [2:0]  req;
    logic [23:0] req_addr;
    logic [23:0] req_wdata;
    logic [2:0]  req_rnw;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic [7:0]  rdata;
    logic        busy;
    logic        a_d;
    logic        cs_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  ad_in;

    // Scheduler view: consumes requests and the AD input, drives strobes.
    modport slave (
        input  req, req_addr, req_wdata, req_rnw, ad_in,
        output grant, done, rdata, busy, a_d, cs_n, rd_n, wr_n, ad_out, ad_oe
    );

    // Requester / pin view: the mirror image of the scheduler.
    modport master (
        output req, req_addr, req_wdata, req_rnw, ad_in,
        input  grant, done, rdata, busy, a_d, cs_n, rd_n, wr_n, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_sched.sv
// Fixed-priority scheduler running one address+data RTC transaction at a time
// and generating the multiplexed-bus strobes from registered outputs.
module rtc_bus_sched #(
    parameter int unsigned T_STROBE = 4,
    parameter int unsigned T_GAP    = 2
) (
    input  logic           clk,
    input  logic           reset,
    rtc_bus_sched_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_DATA,
        S_GAP2,
        S_DONE
    } state_e;

    localparam logic [7:0] STROBE_LOAD = 8'(T_STROBE - 1);
    localparam logic [7:0] GAP_LOAD    = 8'(T_GAP - 1);

    // Phase lengths of zero would underflow the counter load.
    if (T_STROBE < 1 || T_STROBE > 255) begin : g_bad_strobe
        $error("rtc_bus_sched: T_STROBE must be in 1..255");
    end
    if (T_GAP < 1 || T_GAP > 255) begin : g_bad_gap
        $error("rtc_bus_sched: T_GAP must be in 1..255");
    end

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rnw_q, rnw_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        a_d_q, a_d_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic [7:0]  ad_out_q, ad_out_d;
    logic        ad_oe_q, ad_oe_d;
    logic [1:0]  win_idx;

    // Next-state, request latching and next values of every registered output.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rnw_d   = rnw_q;
        grant_d = grant_q;
        rdata_d = rdata_q;
        win_idx = 2'd0;

        unique case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    // init > write-back > refresh
                    if (bus.req[0])      win_idx = 2'd0;
                    else if (bus.req[1]) win_idx = 2'd1;
                    else                 win_idx = 2'd2;
                    grant_d = 3'b001 << win_idx;
                    addr_d  = bus.req_addr[8*win_idx +: 8];
                    wdata_d = bus.req_wdata[8*win_idx +: 8];
                    rnw_d   = bus.req_rnw[win_idx];
                    cnt_d   = STROBE_LOAD;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = GAP_LOAD;
                    state_d = S_GAP1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP1: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = STROBE_LOAD;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 8'd0) begin
                    // The edge that ends DATA is the read sample point.
                    if (rnw_q) rdata_d = bus.ad_in;
                    cnt_d   = GAP_LOAD;
                    state_d = S_GAP2;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP2: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                grant_d = 3'b000;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 3'b000;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave flops directly.
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE) ? grant_q : 3'b000;
        cs_n_d  = !((state_d == S_ADDR) || (state_d == S_DATA));
        wr_n_d  = !((state_d == S_ADDR) || ((state_d == S_DATA) && !rnw_d));
        rd_n_d  = !((state_d == S_DATA) && rnw_d);
        ad_oe_d = (state_d == S_ADDR) || ((state_d == S_DATA) && !rnw_d);

        // a_d and ad_out hold through the gaps.
        a_d_d    = a_d_q;
        ad_out_d = ad_out_q;
        if (state_d == S_ADDR) begin
            a_d_d    = 1'b0;
            ad_out_d = addr_d;
        end else if ((state_d == S_DATA) || (state_d == S_GAP2)) begin
            a_d_d = 1'b1;
            if ((state_d == S_DATA) && !rnw_d) ad_out_d = wdata_d;
        end
    end

    // State, counter, latched request and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            addr_q   <= 8'd0;
            wdata_q  <= 8'd0;
            rnw_q    <= 1'b0;
            grant_q  <= 3'b000;
            done_q   <= 3'b000;
            rdata_q  <= 8'd0;
            busy_q   <= 1'b0;
            a_d_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            ad_out_q <= 8'd0;
            ad_oe_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values together.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rnw_q    <= rnw_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            a_d_q    <= a_d_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.done   = done_q;
    assign bus.rdata  = rdata_q;
    assign bus.busy   = busy_q;
    assign bus.a_d    = a_d_q;
    assign bus.cs_n   = cs_n_q;
    assign bus.rd_n   = rd_n_q;
    assign bus.wr_n   = wr_n_q;
    assign bus.ad_out = ad_out_q;
    assign bus.ad_oe  = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_sched.sv
// Scoreboard bench for rtc_bus_sched: default-parameter instance plus a
// T_STROBE=1/T_GAP=1 instance for the short-timing case.
module tb_rtc_bus_sched;

    localparam int TS       = 4;
    localparam int TG       = 2;
    localparam int LAT      = 2 * (TS + TG);  // grant edge to done edge
    localparam int PERIOD   = LAT + 2;        // grant to next grant
    localparam int F_LAT    = 4;
    localparam int F_PERIOD = 6;

    typedef struct {
        logic [2:0] grant;
        logic       rnw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    typedef struct {
        logic [2:0] grant;
        logic [2:0] done;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         addr_cnt;
        int         wr_cnt;
        int         rd_cnt;
        int         data_start;
        int         grant_cyc;
        int         done_cyc;
        int         bad;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb_q[$];
    logic [7:0] model_rdata = 8'h00;

    rtc_bus_sched_if bus();
    rtc_bus_sched_if fbus();

    rtc_bus_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rtc_bus_sched #(.T_STROBE(1), .T_GAP(1)) dut_fast (
        .clk   (clk),
        .reset (reset),
        .bus   (fbus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor for the default instance, sampled 1 ns after each edge.
    obs_t cur;
    obs_t last_obs;
    int   done_events = 0;
    int   grant_events = 0;
    logic [2:0] prev_grant = 3'b000;

    always @(posedge clk) begin
        #1;
        if (bus.grant !== 3'b000 && prev_grant === 3'b000) begin
            cur = '{default: 0};
            cur.grant      = bus.grant;
            cur.grant_cyc  = cyc;
            cur.data_start = -1;
            grant_events++;
        end
        prev_grant = bus.grant;
        if (bus.cs_n === 1'b0 && bus.a_d === 1'b0) begin
            cur.addr_cnt++;
            cur.addr = bus.ad_out;
            if (bus.wr_n !== 1'b0 || bus.rd_n !== 1'b1 || bus.ad_oe !== 1'b1) cur.bad++;
        end
        if (bus.cs_n === 1'b0 && bus.a_d === 1'b1) begin
            if (cur.data_start < 0) cur.data_start = cyc - cur.grant_cyc;
            if (bus.wr_n === 1'b0) begin
                cur.wr_cnt++;
                cur.wdata = bus.ad_out;
                if (bus.ad_oe !== 1'b1) cur.bad++;
            end
            if (bus.rd_n === 1'b0) begin
                cur.rd_cnt++;
                if (bus.ad_oe !== 1'b0) cur.bad++;
            end
        end
        if (bus.cs_n === 1'b1 && (bus.rd_n !== 1'b1 || bus.wr_n !== 1'b1 || bus.ad_oe !== 1'b0)) cur.bad++;
        if (bus.rd_n === 1'b0 && bus.wr_n === 1'b0) cur.bad++;
        if (bus.done !== 3'b000) begin
            cur.done     = bus.done;
            cur.done_cyc = cyc;
            cur.rdata    = bus.rdata;
            last_obs     = cur;
            done_events++;
        end
    end

    // Grant/done timestamps for the short-timing instance.
    int   f_grant_cyc[$];
    int   f_done_cyc[$];
    logic [2:0] f_prev = 3'b000;

    always @(posedge clk) begin
        #1;
        if (fbus.grant !== 3'b000 && f_prev === 3'b000) f_grant_cyc.push_back(cyc);
        f_prev = fbus.grant;
        if (fbus.done !== 3'b000) f_done_cyc.push_back(cyc);
    end

    // Waits (bounded) for the next done pulse; the served requester drops req.
    task automatic wait_txn(output bit ok, output obs_t o);
        int start;
        start = done_events;
        ok = 1'b0;
        o = last_obs;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_events != start) begin
                ok = 1'b1;
                o = last_obs;
                bus.req = bus.req & ~o.done;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.grant !== 3'b000 || bus.done !== 3'b000 || bus.busy !== 1'b0)
            $display("FAIL reset_ctrl: got grant=%b done=%b busy=%b expected 000/000/0", bus.grant, bus.done, bus.busy);
        else pass_cnt++;
        total_cnt++; if ({bus.a_d, bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe} !== 5'b01110)
            $display("FAIL reset_strobes: got a_d,cs_n,rd_n,wr_n,oe=%b expected 01110", {bus.a_d, bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe});
        else pass_cnt++;
        total_cnt++; if (bus.rdata !== 8'h00 || bus.ad_out !== 8'h00)
            $display("FAIL reset_data: got rdata=%h ad_out=%h expected 00/00", bus.rdata, bus.ad_out);
        else pass_cnt++;
        reset = 1'b0;
        model_rdata = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write();
        bit ok; obs_t o; exp_t e;
        bus.req_addr[15:8]  = 8'h10;
        bus.req_wdata[15:8] = 8'h00;
        bus.req_rnw[1]      = 1'b0;
        sb_q.push_back('{grant: 3'b010, rnw: 1'b0, addr: 8'h10, wdata: 8'h00, rdata: model_rdata});
        bus.req[1] = 1'b1;
        wait_txn(ok, o);
        e = sb_q.pop_front();
        total_cnt++; if (!ok) $display("FAIL write_timeout: got no done expected done"); else pass_cnt++;
        total_cnt++; if (o.grant !== e.grant || o.done !== e.grant)
            $display("FAIL write_grant_done: got %b/%b expected %b", o.grant, o.done, e.grant);
        else pass_cnt++;
        total_cnt++; if (o.addr !== e.addr || o.addr_cnt !== TS)
            $display("FAIL write_addr_phase: got addr=%h cycles=%0d expected %h/%0d", o.addr, o.addr_cnt, e.addr, TS);
        else pass_cnt++;
        total_cnt++; if (o.wdata !== e.wdata || o.wr_cnt !== TS || o.rd_cnt !== 0)
            $display("FAIL write_data_phase: got wdata=%h wr=%0d rd=%0d expected %h/%0d/0", o.wdata, o.wr_cnt, o.rd_cnt, e.wdata, TS);
        else pass_cnt++;
        total_cnt++; if (o.data_start !== TS + TG)
            $display("FAIL write_data_start: got %0d expected %0d", o.data_start, TS + TG);
        else pass_cnt++;
        total_cnt++; if (o.done_cyc - o.grant_cyc !== LAT)
            $display("FAIL write_latency: got %0d expected %0d", o.done_cyc - o.grant_cyc, LAT);
        else pass_cnt++;
        total_cnt++; if (o.bad !== 0 || o.rdata !== e.rdata)
            $display("FAIL write_strobes_rdata: got bad=%0d rdata=%h expected 0/%h", o.bad, o.rdata, e.rdata);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0 || bus.grant !== 3'b000)
            $display("FAIL write_idle_after: got busy=%b grant=%b expected 0/000", bus.busy, bus.grant);
        else pass_cnt++;
    endtask

    task automatic test_single_read();
        bit ok; obs_t o; exp_t e;
        bus.ad_in            = 8'h59;
        bus.req_addr[23:16]  = 8'h21;
        bus.req_rnw[2]       = 1'b1;
        model_rdata = 8'h59;
        sb_q.push_back('{grant: 3'b100, rnw: 1'b1, addr: 8'h21, wdata: 8'h00, rdata: model_rdata});
        bus.req[2] = 1'b1;
        wait_txn(ok, o);
        e = sb_q.pop_front();
        total_cnt++; if (!ok || o.done !== e.grant)
            $display("FAIL read_done: got ok=%0d done=%b expected 1/%b", ok, o.done, e.grant);
        else pass_cnt++;
        total_cnt++; if (o.addr !== e.addr || o.rd_cnt !== TS || o.wr_cnt !== 0)
            $display("FAIL read_phases: got addr=%h rd=%0d wr=%0d expected %h/%0d/0", o.addr, o.rd_cnt, o.wr_cnt, e.addr, TS);
        else pass_cnt++;
        total_cnt++; if (o.rdata !== e.rdata || o.bad !== 0)
            $display("FAIL read_rdata: got %h bad=%0d expected %h/0", o.rdata, o.bad, e.rdata);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (done_events !== 2 || bus.rdata !== 8'h59)
            $display("FAIL read_single_done: got events=%0d rdata=%h expected 2/59", done_events, bus.rdata);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        bit ok; obs_t o; exp_t e; int prev_g;
        bus.req_addr  = {8'h03, 8'h02, 8'h01};
        bus.req_wdata = {8'h00, 8'h5A, 8'hA5};
        bus.req_rnw   = 3'b100;
        bus.ad_in     = 8'hC3;
        sb_q.push_back('{grant: 3'b001, rnw: 1'b0, addr: 8'h01, wdata: 8'hA5, rdata: model_rdata});
        sb_q.push_back('{grant: 3'b010, rnw: 1'b0, addr: 8'h02, wdata: 8'h5A, rdata: model_rdata});
        model_rdata = 8'hC3;
        sb_q.push_back('{grant: 3'b100, rnw: 1'b1, addr: 8'h03, wdata: 8'h00, rdata: model_rdata});
        bus.req = 3'b111;
        prev_g = 0;
        for (int k = 0; k < 3; k++) begin
            wait_txn(ok, o);
            e = sb_q.pop_front();
            total_cnt++; if (!ok || o.grant !== e.grant || o.done !== e.grant)
                $display("FAIL cont_order_%0d: got grant=%b done=%b expected %b", k, o.grant, o.done, e.grant);
            else pass_cnt++;
            total_cnt++; if (o.addr !== e.addr || (!e.rnw && o.wdata !== e.wdata) || o.rdata !== e.rdata)
                $display("FAIL cont_data_%0d: got addr=%h wdata=%h rdata=%h expected %h/%h/%h",
                         k, o.addr, o.wdata, o.rdata, e.addr, e.wdata, e.rdata);
            else pass_cnt++;
            total_cnt++; if (o.bad !== 0)
                $display("FAIL cont_overlap_%0d: got %0d bad cycles expected 0", k, o.bad);
            else pass_cnt++;
            if (k > 0) begin
                total_cnt++; if (o.grant_cyc - prev_g !== PERIOD)
                    $display("FAIL cont_period_%0d: got %0d expected %0d", k, o.grant_cyc - prev_g, PERIOD);
                else pass_cnt++;
            end
            prev_g = o.grant_cyc;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_priority_arrival();
        bit ok; obs_t o1, o2; exp_t e; int start; bit seen;
        bus.req_addr[23:16] = 8'h33;
        bus.req_rnw[2]      = 1'b1;
        bus.ad_in           = 8'h7E;
        model_rdata = 8'h7E;
        sb_q.push_back('{grant: 3'b100, rnw: 1'b1, addr: 8'h33, wdata: 8'h00, rdata: model_rdata});
        start = grant_events;
        bus.req = 3'b100;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (grant_events != start) seen = 1'b1;
        end
        total_cnt++; if (!seen) $display("FAIL prio_grant_timeout: got no grant expected grant"); else pass_cnt++;
        // In ADDR now: raise init and disturb the refresh request fields.
        bus.req_addr[23:16] = 8'hEE;
        bus.req_rnw[2]      = 1'b0;
        bus.req_addr[7:0]   = 8'h44;
        bus.req_wdata[7:0]  = 8'h99;
        bus.req_rnw[0]      = 1'b0;
        sb_q.push_back('{grant: 3'b001, rnw: 1'b0, addr: 8'h44, wdata: 8'h99, rdata: model_rdata});
        bus.req[0] = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.grant !== 3'b100)
            $display("FAIL prio_no_preempt: got %b expected 100", bus.grant);
        else pass_cnt++;
        wait_txn(ok, o1);
        e = sb_q.pop_front();
        total_cnt++; if (!ok || o1.done !== e.grant || o1.addr !== e.addr || o1.rd_cnt !== TS || o1.rdata !== e.rdata)
            $display("FAIL prio_refresh: got done=%b addr=%h rd=%0d rdata=%h expected %b/%h/%0d/%h",
                     o1.done, o1.addr, o1.rd_cnt, o1.rdata, e.grant, e.addr, TS, e.rdata);
        else pass_cnt++;
        wait_txn(ok, o2);
        e = sb_q.pop_front();
        total_cnt++; if (!ok || o2.grant !== e.grant || o2.addr !== e.addr || o2.wdata !== e.wdata)
            $display("FAIL prio_init: got grant=%b addr=%h wdata=%h expected %b/%h/%h",
                     o2.grant, o2.addr, o2.wdata, e.grant, e.addr, e.wdata);
        else pass_cnt++;
        total_cnt++; if (o2.grant_cyc - o1.done_cyc !== 2)
            $display("FAIL prio_next_idle: got %0d expected 2", o2.grant_cyc - o1.done_cyc);
        else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok; obs_t o; exp_t e; bit seen; int ev;
        bus.req_addr[15:8]  = 8'h55;
        bus.req_wdata[15:8] = 8'hAA;
        bus.req_rnw[1]      = 1'b0;
        sb_q.push_back('{grant: 3'b010, rnw: 1'b0, addr: 8'h55, wdata: 8'hAA, rdata: model_rdata});
        bus.req[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.cs_n === 1'b0 && bus.a_d === 1'b1) seen = 1'b1;
        end
        total_cnt++; if (!seen) $display("FAIL rst_mid_no_data: got no DATA phase expected DATA"); else pass_cnt++;
        ev = done_events;
        #2;
        reset = 1'b1;
        bus.req = 3'b000;
        void'(sb_q.pop_back());
        model_rdata = 8'h00;
        #1;
        total_cnt++; if ({bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe} !== 4'b1110)
            $display("FAIL rst_mid_strobes: got cs,rd,wr,oe=%b expected 1110", {bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe});
        else pass_cnt++;
        total_cnt++; if (bus.grant !== 3'b000 || bus.rdata !== 8'h00 || bus.done !== 3'b000)
            $display("FAIL rst_mid_ctrl: got grant=%b rdata=%h done=%b expected 000/00/000", bus.grant, bus.rdata, bus.done);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        total_cnt++; if (done_events !== ev)
            $display("FAIL rst_mid_no_done: got %0d dones expected 0", done_events - ev);
        else pass_cnt++;
        bus.req_addr[15:8]  = 8'h66;
        bus.req_wdata[15:8] = 8'h3C;
        sb_q.push_back('{grant: 3'b010, rnw: 1'b0, addr: 8'h66, wdata: 8'h3C, rdata: model_rdata});
        bus.req[1] = 1'b1;
        wait_txn(ok, o);
        e = sb_q.pop_front();
        total_cnt++; if (!ok || o.done !== e.grant || o.addr !== e.addr || o.wdata !== e.wdata || o.rdata !== e.rdata)
            $display("FAIL rst_mid_fresh: got done=%b addr=%h wdata=%h rdata=%h expected %b/%h/%h/%h",
                     o.done, o.addr, o.wdata, o.rdata, e.grant, e.addr, e.wdata, e.rdata);
        else pass_cnt++;
        total_cnt++; if (o.done_cyc - o.grant_cyc !== LAT || o.bad !== 0)
            $display("FAIL rst_mid_fresh_timing: got lat=%0d bad=%0d expected %0d/0", o.done_cyc - o.grant_cyc, o.bad, LAT);
        else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back_fast();
        fbus.req_addr[15:8]  = 8'h12;
        fbus.req_wdata[15:8] = 8'h34;
        fbus.req_rnw[1]      = 1'b0;
        fbus.req[1] = 1'b1;
        for (int i = 0; i < 100 && f_done_cyc.size() < 3; i++) @(negedge clk);
        fbus.req = 3'b000;
        total_cnt++; if (f_done_cyc.size() < 3 || f_grant_cyc.size() < 3) begin
            $display("FAIL fast_count: got %0d grants %0d dones expected 3/3", f_grant_cyc.size(), f_done_cyc.size());
        end else begin
            pass_cnt++;
            total_cnt++; if (f_done_cyc[0] - f_grant_cyc[0] !== F_LAT)
                $display("FAIL fast_latency: got %0d expected %0d", f_done_cyc[0] - f_grant_cyc[0], F_LAT);
            else pass_cnt++;
            total_cnt++; if (f_grant_cyc[1] - f_grant_cyc[0] !== F_PERIOD || f_grant_cyc[2] - f_grant_cyc[1] !== F_PERIOD)
                $display("FAIL fast_period: got %0d,%0d expected %0d", f_grant_cyc[1] - f_grant_cyc[0],
                         f_grant_cyc[2] - f_grant_cyc[1], F_PERIOD);
            else pass_cnt++;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        bus.req        = 3'b000;
        bus.req_addr   = 24'h0;
        bus.req_wdata  = 24'h0;
        bus.req_rnw    = 3'b000;
        bus.ad_in      = 8'h00;
        fbus.req       = 3'b000;
        fbus.req_addr  = 24'h0;
        fbus.req_wdata = 24'h0;
        fbus.req_rnw   = 3'b000;
        fbus.ad_in     = 8'h00;

        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_priority_arrival();
        test_reset_mid();
        test_back_to_back_fast();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
